fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Parametrised successor to the single-cycle PC/adder/instruction-memory path: a PC register plus an IF/ID pipeline register, with start gating, stall, flush and branch/jump redirect. It drives the address port of the combinational instruction memory and presents a registered instruction, PC, next-PC and valid flag to decode. It is the front end of the pipelined CPU top.

Parameters:
ADDR_W, 32, width of PC and all address ports
INSTR_W, 32, instruction width
RESET_PC, 32'h0000_0000, PC value after reset and in IDLE
PC_STEP, 4, sequential PC increment; must be a power of two ≥1

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-high
start_i  in  1  level: 1 = fetch enabled, 0 = pause
stall_i  in  1  hold PC and IF/ID contents (load-use or structural hazard)
flush_i  in  1  invalidate IF/ID next cycle; PC unaffected
redirect_i  in  1  load redirect_pc_i into PC, flush IF/ID
redirect_pc_i  in  ADDR_W  branch/jump target
imem_addr_o  out  ADDR_W  fetch address to instruction memory (= PC register)
imem_data_i  in  INSTR_W  instruction from memory, combinational from imem_addr_o
instr_o  out  INSTR_W  IF/ID instruction
pc_o  out  ADDR_W  IF/ID PC of instr_o
pc_next_o  out  ADDR_W  IF/ID pc_o + PC_STEP
valid_o  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (rst_i=1 at a rising edge, any state, overrides everything): state=IDLE, PC=RESET_PC, instr_o=0, pc_o=0, pc_next_o=0, valid_o=0.
- States: IDLE, RUN, PAUSE.
  - IDLE: PC held at RESET_PC, valid_o←0; redirect_i and stall_i ignored; start_i=1 → RUN (first fetch occurs in the RUN cycle, not the transition cycle).
  - RUN: start_i=0 → PAUSE. Otherwise per-cycle priority: redirect_i > stall_i > flush_i > normal.
  - PAUSE: PC and IF/ID instr_o/pc_o/pc_next_o held; valid_o←0. redirect_i loads PC (state stays PAUSE). start_i=1 → RUN.
- RUN normal: IF/ID ← {imem_data_i, PC, PC+PC_STEP}, valid_o←1, PC←PC+PC_STEP.
- RUN redirect_i: PC←redirect_pc_i with low log2(PC_STEP) bits forced to 0; valid_o←0; IF/ID data don't-care but must be held. Redirect wins over a simultaneous stall_i.
- RUN stall_i (no redirect): PC and all IF/ID registers, including valid_o, held unchanged.
- RUN flush_i (no redirect, no stall): PC←PC+PC_STEP, IF/ID loaded as normal but valid_o←0.
- Latency: instruction at address A appears on instr_o with valid_o=1 exactly one clock after imem_addr_o=A in an unstalled RUN cycle.
- Arithmetic: PC+PC_STEP is modulo 2^ADDR_W; wrap from all-ones-aligned to 0 is silent.
- imem_addr_o is a pure wire from the PC register; no combinational path from any input to any output.

Optional Feature:
FETCH_PERF_CNT_EN — defined: adds outputs fetch_cnt_o[31:0] (increments on each cycle valid_o is loaded with 1) and stall_cnt_o[31:0] (increments on each RUN cycle with stall_i=1 and redirect_i=0). Both clear on rst_i and saturate at 32'hFFFF_FFFF. Not defined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset then start_i=1 with imem returning addr-as-data: after 1 transition cycle, instr_o=0,4,8… with pc_o equal, pc_next_o=pc_o+4, valid_o=1 every cycle.
- RUN at PC=0x10, stall_i=1 for 3 cycles: imem_addr_o stays 0x10, instr_o/pc_o/valid_o frozen; on release, next instr_o from 0x10.
- RUN at PC=0x20, redirect_i=1 with stall_i=1, redirect_pc_i=0x103: next cycle PC=0x100, valid_o=0; following cycle pc_o=0x100, valid_o=1.
- RUN, start_i=0 for 2 cycles, then 1: valid_o=0 during pause, PC unchanged, fetch resumes at held PC; redirect to 0x40 during pause → resumes at 0x40.
- PC=32'hFFFF_FFFC, normal fetch: next PC=0, pc_next_o=0; rst_i asserted mid-RUN with redirect_i=1 → PC=RESET_PC, valid_o=0, state IDLE.
- With FETCH_PERF_CNT_EN: 5 fetches, 2 stall cycles, 1 redirect → fetch_cnt_o=5, stall_cnt_o=2; rst_i clears both.

Source files
------------

// File: rtl/fetch_stage.sv
// Pipelined fetch front end: PC register, IF/ID register, start/stall/flush/redirect control.
// Optional macro FETCH_PERF_CNT_EN adds saturating fetch and stall counters.
module fetch_stage #(
  parameter int unsigned            ADDR_W   = 32,
  parameter int unsigned            INSTR_W  = 32,
  parameter logic [ADDR_W-1:0]      RESET_PC = '0,
  parameter int unsigned            PC_STEP  = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic [INSTR_W-1:0] imem_data_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [ADDR_W-1:0]  pc_next_o,
  output logic               valid_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_cnt_o,
  output logic [31:0]        stall_cnt_o
`endif
);

  // state | meaning
  // IDLE  | PC parked at RESET_PC, nothing fetched
  // RUN   | fetching, redirect > stall > flush > normal
  // PAUSE | PC and IF/ID held, redirect may still retarget PC
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(PC_STEP - 1));

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0]   instr_q;
  logic [ADDR_W-1:0]    pc_id_q;
  logic [ADDR_W-1:0]    pc_next_q;
  logic                 valid_q, valid_d;
  logic                 if_load;
  logic [ADDR_W-1:0]    pc_inc;
  logic [ADDR_W-1:0]    redirect_aligned;

  assign pc_inc           = pc_q + STEP;
  assign redirect_aligned = redirect_pc_i & ALIGN_MASK;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        pc_d    = RESET_PC;
        valid_d = 1'b0;
        if (start_i) state_d = RUN;
      end
      RUN: begin
        if (!start_i) begin
          state_d = PAUSE;
          valid_d = 1'b0;
        end else if (redirect_i) begin
          pc_d    = redirect_aligned;
          valid_d = 1'b0;
        end else if (stall_i) begin
          pc_d    = pc_q;
          valid_d = valid_q;
        end else begin
          if_load = 1'b1;
          valid_d = !flush_i;
          pc_d    = pc_inc;
        end
      end
      PAUSE: begin
        valid_d = 1'b0;
        if (redirect_i) pc_d = redirect_aligned;
        if (start_i) state_d = RUN;
      end
      default: begin
        state_d = IDLE;
        pc_d    = RESET_PC;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      pc_id_q   <= '0;
      pc_next_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      if (if_load) begin
        instr_q   <= imem_data_i;
        pc_id_q   <= pc_q;
        pc_next_q <= pc_inc;
      end
    end
  end

  assign imem_addr_o = pc_q;
  assign instr_o     = instr_q;
  assign pc_o        = pc_id_q;
  assign pc_next_o   = pc_next_q;
  assign valid_o     = valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;
  logic        fetch_inc, stall_inc;

  // Only fresh loads of a valid instruction count; a stall holding valid_o=1 does not.
  assign fetch_inc = if_load && valid_d;
  assign stall_inc = (state_q == RUN) && stall_i && !redirect_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (fetch_inc && (fetch_cnt_q != 32'hFFFF_FFFF)) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (stall_inc && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage with an address-derived instruction memory.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, start, stall, flush, redir;
  logic [31:0] rpc;
  logic [31:0] imem_addr, imem_data, instr, pc_o, pc_next;
  logic        valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  assign imem_data = mem_f(imem_addr);

  fetch_stage dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .stall_i      (stall),
    .flush_i      (flush),
    .redirect_i   (redir),
    .redirect_pc_i(rpc),
    .imem_addr_o  (imem_addr),
    .imem_data_i  (imem_data),
    .instr_o      (instr),
    .pc_o         (pc_o),
    .pc_next_o    (pc_next),
    .valid_o      (valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt_o  (fetch_cnt),
    .stall_cnt_o  (stall_cnt)
`endif
  );

  typedef struct packed {
    logic        st, sl, fl, rd;
    logic [31:0] rpc;
    logic [31:0] addr;
    logic        v;
    logic [31:0] pc;
    logic [31:0] pcn;
    logic        chk;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, sl, fl, rd, input logic [31:0] r, a,
                     input logic v, input logic [31:0] p, pn, input logic c);
    vec_t t;
    t = '{st: st, sl: sl, fl: fl, rd: rd, rpc: r, addr: a, v: v, pc: p, pcn: pn, chk: c};
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, sl, fl, rd, input logic [31:0] r);
    start = st; stall = sl; flush = fl; redir = rd; rpc = r;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 32'h0);

    // stimulus table: inputs | imem_addr, valid, pc_o, pc_next, instr check
    add(1,0,0,0, 32'h0,        32'h0000_0000, 0, 32'h0,   32'h0,   0);
    add(1,0,0,0, 32'h0,        32'h0000_0004, 1, 32'h0,   32'h4,   1);
    add(1,0,0,0, 32'h0,        32'h0000_0008, 1, 32'h4,   32'h8,   1);
    add(1,0,0,0, 32'h0,        32'h0000_000C, 1, 32'h8,   32'hC,   1);
    add(1,0,0,0, 32'h0,        32'h0000_0010, 1, 32'hC,   32'h10,  1);
    add(1,1,0,0, 32'h0,        32'h0000_0010, 1, 32'hC,   32'h10,  1);
    add(1,1,0,0, 32'h0,        32'h0000_0010, 1, 32'hC,   32'h10,  1);
    add(1,1,0,0, 32'h0,        32'h0000_0010, 1, 32'hC,   32'h10,  1);
    add(1,0,0,0, 32'h0,        32'h0000_0014, 1, 32'h10,  32'h14,  1);
    add(1,0,0,0, 32'h0,        32'h0000_0018, 1, 32'h14,  32'h18,  1);
    add(1,0,0,0, 32'h0,        32'h0000_001C, 1, 32'h18,  32'h1C,  1);
    add(1,0,0,0, 32'h0,        32'h0000_0020, 1, 32'h1C,  32'h20,  1);
    add(1,1,0,1, 32'h103,      32'h0000_0100, 0, 32'h1C,  32'h20,  1);
    add(1,0,0,0, 32'h0,        32'h0000_0104, 1, 32'h100, 32'h104, 1);
    add(1,0,1,0, 32'h0,        32'h0000_0108, 0, 32'h104, 32'h108, 1);
    add(1,0,0,0, 32'h0,        32'h0000_010C, 1, 32'h108, 32'h10C, 1);
    add(0,0,0,0, 32'h0,        32'h0000_010C, 0, 32'h108, 32'h10C, 1);
    add(0,0,0,0, 32'h0,        32'h0000_010C, 0, 32'h108, 32'h10C, 1);
    add(1,0,0,0, 32'h0,        32'h0000_010C, 0, 32'h108, 32'h10C, 1);
    add(1,0,0,0, 32'h0,        32'h0000_0110, 1, 32'h10C, 32'h110, 1);
    add(0,0,0,0, 32'h0,        32'h0000_0110, 0, 32'h10C, 32'h110, 1);
    add(0,0,0,1, 32'h40,       32'h0000_0040, 0, 32'h10C, 32'h110, 1);
    add(1,0,0,0, 32'h0,        32'h0000_0040, 0, 32'h10C, 32'h110, 1);
    add(1,0,0,0, 32'h0,        32'h0000_0044, 1, 32'h40,  32'h44,  1);
    add(1,0,0,1, 32'hFFFF_FFFC,32'hFFFF_FFFC, 0, 32'h40,  32'h44,  1);
    add(1,0,0,0, 32'h0,        32'h0000_0000, 1, 32'hFFFF_FFFC, 32'h0, 1);
    add(1,0,0,0, 32'h0,        32'h0000_0004, 1, 32'h0,   32'h4,   1);

    tick(); tick();
    check("rst_addr",  imem_addr, 32'h0);
    check("rst_valid", {31'b0, valid}, 32'h0);
    check("rst_pc",    pc_o, 32'h0);
    check("rst_pcn",   pc_next, 32'h0);
    check("rst_instr", instr, 32'h0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].st, vecs[i].sl, vecs[i].fl, vecs[i].rd, vecs[i].rpc);
      tick();
      check($sformatf("v%0d_addr", i),  imem_addr, vecs[i].addr);
      check($sformatf("v%0d_valid", i), {31'b0, valid}, {31'b0, vecs[i].v});
      check($sformatf("v%0d_pc", i),    pc_o, vecs[i].pc);
      check($sformatf("v%0d_pcn", i),   pc_next, vecs[i].pcn);
      if (vecs[i].chk) check($sformatf("v%0d_instr", i), instr, mem_f(vecs[i].pc));
    end

    // reset mid-RUN overrides a simultaneous redirect
    rst = 1'b1;
    drive(1, 0, 0, 1, 32'h80);
    tick();
    check("midrst_addr",  imem_addr, 32'h0);
    check("midrst_valid", {31'b0, valid}, 32'h0);
    check("midrst_pc",    pc_o, 32'h0);
    check("midrst_instr", instr, 32'h0);
    rst = 1'b0;
    // IDLE ignores redirect and stall
    drive(0, 1, 0, 1, 32'h80);
    tick();
    check("idle_addr",  imem_addr, 32'h0);
    check("idle_valid", {31'b0, valid}, 32'h0);
    // transition cycle does not fetch, proving the reset landed in IDLE
    drive(1, 0, 0, 0, 32'h0);
    tick();
    check("idle2run_addr",  imem_addr, 32'h0);
    check("idle2run_valid", {31'b0, valid}, 32'h0);
    tick();
    check("first_valid", {31'b0, valid}, 32'h1);
    check("first_pc",    pc_o, 32'h0);
    check("first_instr", instr, mem_f(32'h0));
    check("first_addr",  imem_addr, 32'h4);

`ifdef FETCH_PERF_CNT_EN
    rst = 1'b1;
    drive(0, 0, 0, 0, 32'h0);
    tick();
    rst = 1'b0;
    drive(1, 0, 0, 0, 32'h0);
    tick();
    for (int k = 0; k < 5; k++) tick();
    drive(1, 1, 0, 0, 32'h0);
    tick(); tick();
    drive(1, 1, 0, 1, 32'h200);
    tick();
    drive(0, 0, 0, 0, 32'h0);
    tick();
    check("perf_fetch", fetch_cnt, 32'd5);
    check("perf_stall", stall_cnt, 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("perf_fetch_clr", fetch_cnt, 32'd0);
    check("perf_stall_clr", stall_cnt, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
